// File: rtl/mul_div_unit.sv
// Iterative RV32M-style multiply/divide unit: one result bit per clock,
// shift-add multiply and restoring divide, early exit on divide-by-zero
// and signed overflow.
//
// state | meaning
// IDLE  | ready for a request; in_ready high
// BUSY  | iterating, one product/quotient bit per edge
// DONE  | result held on result, out_valid high until out_ready
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nxt;
  logic [2:0]         op_q;
  logic [2*WIDTH-1:0] acc;        // {upper partial / remainder, multiplier / dividend}
  logic [WIDTH-1:0]   opnd;       // multiplicand or divisor magnitude
  logic [CNT_W-1:0]   count;
  logic               neg_q;      // negate product / quotient at the end
  logic               neg_r;      // negate remainder at the end
  logic               special_q;  // early-exit case; answer preloaded in acc low half

  logic               accept;
  logic               last_iter;

  // accept-time decode
  logic               sign_a, sign_b, div_zero, div_ovf, special;
  logic [WIDTH-1:0]   abs_a, abs_b, spec_val, lo_init;

  // iteration datapath
  logic [WIDTH:0]     mul_sum, rem_sh, div_diff;
  logic               div_q;
  logic [2*WIDTH-1:0] mul_step, div_step, step, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, final_res;

  assign accept    = (state == IDLE) && in_valid && !abort;
  assign last_iter = (count == LAST_CNT);

  // operand conditioning and special-case detection for the request on the inputs
  always_comb begin
    sign_a   = 1'b0;
    sign_b   = 1'b0;
    spec_val = '0;
    case (op)
      OP_MULH, OP_DIV, OP_REM: begin
        sign_a = a[WIDTH-1];
        sign_b = b[WIDTH-1];
      end
      OP_MULHSU: sign_a = a[WIDTH-1];
      default: ;
    endcase
    abs_a    = sign_a ? -a : a;
    abs_b    = sign_b ? -b : b;
    div_zero = op[2] && (b == '0);
    div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (a == MOST_NEG) && (b == '1);
    special  = div_zero || div_ovf;
    // op[1] separates REM/REMU from DIV/DIVU
    if (div_zero)
      spec_val = op[1] ? a : '1;
    else if (div_ovf)
      spec_val = op[1] ? '0 : a;
    if (special)
      lo_init = spec_val;
    else
      lo_init = op[2] ? abs_a : abs_b;
  end

  // one shift-add or restoring-divide step, plus final sign fix-up and selection
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_step = {mul_sum, acc[WIDTH-1:1]};
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    div_diff = rem_sh - {1'b0, opnd};
    div_q    = ~div_diff[WIDTH];
    div_step = {div_q ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0], acc[WIDTH-2:0], div_q};
    step     = op_q[2] ? div_step : mul_step;
    prod_fix = neg_q ? -step : step;
    quo_fix  = neg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
    rem_fix  = neg_r ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
    case (op_q)
      OP_MUL:                      final_res = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:             final_res = quo_fix;
      default:                     final_res = rem_fix;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // next-state and handshake outputs; abort wins over completion and out_ready
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept)
          state_nxt = BUSY;
      end
      BUSY: begin
        if (abort)
          state_nxt = IDLE;
        else if (special_q || last_iter)
          state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (abort || out_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // datapath registers: load on accept, iterate in BUSY, capture result on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      acc       <= '0;
      opnd      <= '0;
      count     <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      special_q <= 1'b0;
      result    <= '0;
    end else if (accept) begin
      op_q      <= op;
      acc       <= {{WIDTH{1'b0}}, lo_init};
      opnd      <= op[2] ? abs_b : abs_a;
      count     <= '0;
      neg_q     <= sign_a ^ sign_b;
      neg_r     <= sign_a;
      special_q <= special;
    end else if ((state == BUSY) && !abort) begin
      if (special_q) begin
        result <= acc[WIDTH-1:0];
      end else begin
        acc <= step;
        if (last_iter)
          result <= final_res;
        else
          count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit (WIDTH=32): directed cases, randomized
// operations against an arithmetic reference model, backpressure, abort, reset.
module tb_mul_div_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          abort;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;

  int checks = 0;
  int errors = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  // RISC-V M semantics computed with 64-bit integer arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy;
    longint unsigned ux, uy;
    logic [63:0]     p;
    logic            ovf;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ux  = {32'b0, x};
    uy  = {32'b0, y};
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    p   = '0;
    case (o)
      3'd0: begin p = ux * uy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * longint'(uy); return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ovf) return x;
        p = sx / sy; return p[31:0];
      end
      3'd5: begin
        if (y == 0) return 32'hFFFF_FFFF;
        return x / y;
      end
      3'd6: begin
        if (y == 0) return x;
        if (ovf) return 32'h0;
        p = sx % sy; return p[31:0];
      end
      default: begin
        if (y == 0) return x;
        return x % y;
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o[2] && y == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return W;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // present a request at the current falling edge until accepted; scramble inputs afterwards
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int edges, output bit to);
    bit acc_now;
    op       = o;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    edges    = 0;
    acc_now  = 1'b0;
    while (!acc_now && edges < 50) begin
      acc_now = in_ready;
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    in_valid = 1'b0;
    op       = 3'($urandom_range(0, 7));
    a        = $urandom;
    b        = $urandom;
    to       = !acc_now;
  endtask

  task automatic wait_done(output int lat, output logic [31:0] res, output bit to);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    to  = !out_valid;
    res = result;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output int lat, output bit to);
    int edges;
    bit ito;
    issue(o, x, y, edges, ito);
    if (ito) begin
      to  = 1'b1;
      lat = -1;
      res = 'x;
    end else begin
      wait_done(lat, res, to);
      if (!to) consume();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; abort = 1'b0; out_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h, expected 1 0 00000000", in_ready, out_valid, result);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [2:0]  t_op  [12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                                3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] t_a   [12] = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF,
                                32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] t_b   [12] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF,
                                32'd2, 32'd2, 32'd7, 32'd7,
                                32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] t_exp [12] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h4000_0000, 32'hFFFF_FFFF,
                                32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int          t_lat [12] = '{32, 32, 32, 32, 32, 32, 32, 32, 1, 1, 1, 1};
    logic [31:0] res;
    int          lat;
    bit          to;
    for (int i = 0; i < 12; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], res, lat, to);
      checks++;
      if (to) begin
        errors++;
        $display("FAIL directed_%0d_timeout: no result, expected %h", i, t_exp[i]);
      end else begin
        if (res !== t_exp[i]) begin
          errors++;
          $display("FAIL directed_%0d_result: got %h expected %h", i, res, t_exp[i]);
        end
        checks++;
        if (lat != t_lat[i]) begin
          errors++;
          $display("FAIL directed_%0d_latency: got %0d expected %0d", i, lat, t_lat[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] x, y, res, exp;
    int          lat;
    bit          to;
    for (int i = 0; i < 60; i++) begin
      o   = 3'($urandom_range(0, 7));
      x   = rand_operand();
      y   = rand_operand();
      exp = ref_model(o, x, y);
      run_op(o, x, y, res, lat, to);
      checks++;
      if (to || res !== exp) begin
        errors++;
        $display("FAIL random_result op=%0d a=%h b=%h: got %h expected %h (timeout=%0b)", o, x, y, res, exp, to);
      end
      checks++;
      if (lat != ref_latency(o, x, y)) begin
        errors++;
        $display("FAIL random_latency op=%0d a=%h b=%h: got %0d expected %0d", o, x, y, lat, ref_latency(o, x, y));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] x, y, res, res2, exp;
    int          lat, edges;
    bit          to;
    x   = $urandom;
    y   = $urandom;
    exp = ref_model(3'd1, x, y);
    issue(3'd1, x, y, edges, to);
    wait_done(lat, res, to);
    checks++;
    if (to || res !== exp) begin
      errors++;
      $display("FAIL backpressure_result: got %h expected %h", res, exp);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || result !== exp || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold_%0d: out_valid=%b result=%h in_ready=%b, expected 1 %h 0",
                 i, out_valid, result, in_ready, exp);
      end
    end
    out_ready = 1'b1;
    issue(3'd5, 32'd1000, 32'd10, edges, to);
    out_ready = 1'b0;
    checks++;
    if (to || edges != 2) begin
      errors++;
      $display("FAIL back_to_back_accept: accepted after %0d edges, expected 2", edges);
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_busy: out_valid=%b in_ready=%b, expected 0 0", out_valid, in_ready);
    end
    wait_done(lat, res2, to);
    if (!to) consume();
    checks++;
    if (to || res2 !== 32'd100) begin
      errors++;
      $display("FAIL back_to_back_result: got %h expected %h", res2, 32'd100);
    end
  endtask

  task automatic test_abort();
    logic [31:0] res;
    int          lat, edges;
    bit          to, seen;
    issue(3'd4, $urandom, 32'($urandom_range(1, 1000)), edges, to);
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_no_valid: out_valid rose=%b, expected 0", seen);
    end
    run_op(3'd0, 32'd3, 32'd4, res, lat, to);
    checks++;
    if (to || res !== 32'd12 || lat != W) begin
      errors++;
      $display("FAIL abort_then_mul: got %h lat %0d expected %h lat %0d", res, lat, 32'd12, W);
    end
    // abort in IDLE blocks acceptance
    op = 3'd0; a = 32'd2; b = 32'd2; in_valid = 1'b1; abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; abort = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle: in_ready=%b, expected 1", in_ready);
    end
    // abort in DONE drops the result
    issue(3'd0, 32'd5, 32'd6, edges, to);
    wait_done(lat, res, to);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (to || res !== 32'd30 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_done: result=%h out_valid=%b in_ready=%b, expected 0000001e 0 1", res, out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int          lat, edges;
    bit          to;
    issue(3'd5, $urandom, 32'($urandom_range(1, 50)), edges, to);
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0) begin
      errors++;
      $display("FAIL reset_mid: out_valid=%b in_ready=%b result=%h, expected 0 1 00000000", out_valid, in_ready, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(3'd5, 32'd9, 32'd3, res, lat, to);
    checks++;
    if (to || res !== 32'd3 || lat != W) begin
      errors++;
      $display("FAIL reset_then_divu: got %h lat %0d expected %h lat %0d", res, lat, 32'd3, W);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
